// File: rtl/vga_scanout_if.sv
// VRAM read port between the VGA scanout (master) and the CPU-side VRAM (slave).
// Timing: the master updates gpu_address on a pixel tick. The slave returns vram_out
// one clk later and holds it. There is no valid/ready pair: the contract is
// purely positional.
interface vga_scanout_if;
  logic [31:0] gpu_address;
  logic [7:0]  vram_out;

  modport master (output gpu_address, input  vram_out);
  modport slave  (input  gpu_address, output vram_out);
endinterface

// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout: walks a centred IMG_W x IMG_H grayscale image out of VRAM
// and registers it to the DAC with sync/blank aligned one pixel tick behind the counters.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IMG_W    = 300,
  parameter int IMG_H    = 300,
  parameter int IMG_X    = 170,
  parameter int IMG_Y    = 90,
  parameter logic [7:0] BORDER = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pix_ce,
  vga_scanout_if.master        vram,
  output logic [7:0]           rgb_out,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 blank_n,
  output logic                 frame_done
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
  localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] IX0    = 16'(IMG_X);
  localparam logic [15:0] IX1    = 16'(IMG_X + IMG_W);
  localparam logic [15:0] IY0    = 16'(IMG_Y);
  localparam logic [15:0] IY1    = 16'(IMG_Y + IMG_H);
  localparam logic [16:0] A_LAST = 17'(IMG_W * IMG_H - 1);

  logic [15:0] r_h_cnt, r_v_cnt;
  logic [16:0] r_addr, r_addr_next;
  logic        r_s1_in_img, r_s1_blank_n, r_s1_hsync, r_s1_vsync, r_s1_last;
  logic        r_done_pend;

  logic        w_in_img, w_origin, w_blank_n, w_hsync, w_vsync;
  logic [16:0] w_addr_cur;

  assign w_in_img  = (r_h_cnt >= IX0) && (r_h_cnt < IX1) &&
                     (r_v_cnt >= IY0) && (r_v_cnt < IY1);
  assign w_origin  = (r_h_cnt == 16'd0) && (r_v_cnt == 16'd0);
  // The address walk restarts at the top-left of every frame, even if the image sits there.
  assign w_addr_cur = w_origin ? 17'd0 : r_addr_next;
  assign w_blank_n = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hsync   = !((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
  assign w_vsync   = !((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));

  assign vram.gpu_address = {15'd0, r_addr};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h_cnt <= 16'd0;
      r_v_cnt <= 16'd0;
    end else if (pix_ce) begin
      if (r_h_cnt == H_LAST) begin
        r_h_cnt <= 16'd0;
        r_v_cnt <= (r_v_cnt == V_LAST) ? 16'd0 : r_v_cnt + 16'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 16'd1;
      end
    end
  end

  // Stage 0: issue the VRAM address and capture per-pixel flags for stage 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr       <= 17'd0;
      r_addr_next  <= 17'd0;
      r_s1_in_img  <= 1'b0;
      r_s1_blank_n <= 1'b0;
      r_s1_hsync   <= 1'b1;
      r_s1_vsync   <= 1'b1;
      r_s1_last    <= 1'b0;
    end else if (pix_ce) begin
      if (w_in_img) begin
        r_addr      <= w_addr_cur;
        r_addr_next <= w_addr_cur + 17'd1;
      end else if (w_origin) begin
        r_addr_next <= 17'd0;
      end
      r_s1_in_img  <= w_in_img;
      r_s1_blank_n <= w_blank_n;
      r_s1_hsync   <= w_hsync;
      r_s1_vsync   <= w_vsync;
      r_s1_last    <= w_in_img && (w_addr_cur == A_LAST);
    end
  end

  // Stage 1: vram_out has settled for the address issued on the previous tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_out <= 8'h00;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      blank_n <= 1'b0;
    end else if (pix_ce) begin
      rgb_out <= r_s1_in_img  ? vram.vram_out :
                 r_s1_blank_n ? BORDER        : 8'h00;
      hsync   <= r_s1_hsync;
      vsync   <= r_s1_vsync;
      blank_n <= r_s1_blank_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done_pend <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      r_done_pend <= pix_ce && r_s1_last;
      frame_done  <= r_done_pend;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Randomized-cadence bench for vga_scanout using a reduced raster; a coordinate-level
// model predicts every output on every clk, with a few literal pins on top.
module tb_vga_scanout;
  localparam int HA = 40, HF = 4, HS = 6, HB = 5;
  localparam int VA = 20, VF = 2, VS = 2, VB = 3;
  localparam int IW = 12, IH = 8, IX = 10, IY = 5;
  localparam logic [7:0] BRD = 8'hA5;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic reset;
  logic pix_ce;
  logic [7:0] rgb_out;
  logic hsync, vsync, blank_n, frame_done;

  vga_scanout_if vif ();

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .IMG_W(IW), .IMG_H(IH), .IMG_X(IX), .IMG_Y(IY), .BORDER(BRD)
  ) dut (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .vram(vif.master),
    .rgb_out(rgb_out), .hsync(hsync), .vsync(vsync),
    .blank_n(blank_n), .frame_done(frame_done)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- VRAM model ----------------
  function automatic logic [7:0] vram_fn(input int a);
    logic [16:0] x;
    x = a[16:0];
    return x[7:0] ^ {1'b0, x[16:10]};
  endfunction

  always @(posedge clk) vif.vram_out <= vram_fn(int'(vif.gpu_address[16:0]));

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit in_img(input int h, input int v);
    return (h >= IX) && (h < IX + IW) && (v >= IY) && (v < IY + IH);
  endfunction

  int unsigned n = 0;       // pixel ticks since reset release
  int e_addr = 0;
  logic [7:0] e_rgb = 8'h00;
  logic e_hs = 1'b1, e_vs = 1'b1, e_bl = 1'b0, e_done = 1'b0;
  bit d_pend = 1'b0;

  always @(posedge clk or negedge reset) begin
    int c, h, v;
    if (!reset) begin
      n = 0; e_addr = 0; e_rgb = 8'h00;
      e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_done = 1'b0; d_pend = 1'b0;
    end else begin
      e_done = d_pend;
      d_pend = 1'b0;
      if (pix_ce) begin
        n++;
        if (n >= 2) begin
          c = int'(n) - 2;
          h = c % HT;
          v = (c / HT) % VT;
          e_bl = (h < HA) && (v < VA);
          e_hs = !((h >= HA + HF) && (h < HA + HF + HS));
          e_vs = !((v >= VA + VF) && (v < VA + VF + VS));
          if (in_img(h, v)) begin
            e_rgb = vram_fn((v - IY) * IW + (h - IX));
            if ((v - IY) * IW + (h - IX) == IW * IH - 1) d_pend = 1'b1;
          end else begin
            e_rgb = e_bl ? BRD : 8'h00;
          end
        end
        c = int'(n) - 1;
        h = c % HT;
        v = (c / HT) % VT;
        if (in_img(h, v)) e_addr = (v - IY) * IW + (h - IX);
      end
    end
  end

  // ---------------- compare process ----------------
  bit chk_en = 1'b0;
  int phase = 0;
  int unsigned seen_n = 0;
  int hs_low = 0, vs_low = 0, bl_hi = 0, done_a = 0, done_b = 0, max_addr = 0;

  always @(negedge clk) begin
    int c;
    bit new_tick;
    if (chk_en) begin
      chk("gpu_address", vif.gpu_address, 32'(e_addr));
      chk("rgb_out", 32'(rgb_out), 32'(e_rgb));
      chk("hsync", 32'(hsync), 32'(e_hs));
      chk("vsync", 32'(vsync), 32'(e_vs));
      chk("blank_n", 32'(blank_n), 32'(e_bl));
      chk("frame_done", 32'(frame_done), 32'(e_done));
      new_tick = (n != seen_n);
      seen_n = n;
      if (phase == 1) begin
        if (frame_done) done_a++;
        if (int'(vif.gpu_address) > max_addr) max_addr = int'(vif.gpu_address);
        if (new_tick && n >= 2 && n <= 3 * FT + 1) begin
          if (!hsync) hs_low++;
          if (!vsync) vs_low++;
          if (blank_n) bl_hi++;
          c = int'(n) - 2;
          if (c == IY * HT + IX)                         chk("pin_first_px", 32'(rgb_out), 32'h00);
          if (c == IY * HT + IX + 1)                     chk("pin_second_px", 32'(rgb_out), 32'h01);
          if (c == (IY + IH - 1) * HT + IX + IW - 1)     chk("pin_last_px", 32'(rgb_out), 32'h5F);
          if (c == (IY + IH - 1) * HT + IX + IW)         chk("pin_border", 32'(rgb_out), 32'hA5);
          if (c == HA + 2)                               chk("pin_hblank", 32'(rgb_out), 32'h00);
        end
      end else if (phase == 2) begin
        if (frame_done) done_b++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk) pix_ce = 1'b1;
    @(negedge clk) pix_ce = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic run_until_n(input int unsigned target, input string nm);
    int guard = 0;
    while (n < target && guard < 30000) begin
      tick();
      guard++;
    end
    chk({nm, "_timeout"}, 32'(n >= target), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    bit stalled = 1'b0;
    reset = 1'b0;
    pix_ce = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    // reset held while pix_ce keeps toggling
    for (int i = 0; i < 20; i++) @(negedge clk) pix_ce = ~pix_ce;
    @(negedge clk);
    pix_ce = 1'b0;
    reset = 1'b1;
    phase = 1;

    guard = 0;
    while (n < 3 * FT + 1 && guard < 30000) begin
      tick();
      guard++;
      if (!stalled && n == FT + (IY + 3) * HT + IX + 5) begin
        stalled = 1'b1;
        repeat (50) @(negedge clk);
      end
    end
    chk("three_frames_timeout", 32'(n >= 3 * FT + 1), 32'd1);
    chk("stall_reached", 32'(stalled), 32'd1);
    repeat (3) @(negedge clk);
    chk("pin_hsync_low_ticks", 32'(hs_low), 32'(3 * VT * 6));
    chk("pin_vsync_low_ticks", 32'(vs_low), 32'(3 * 2 * HT));
    chk("pin_blank_hi_ticks", 32'(bl_hi), 32'(3 * 40 * 20));
    chk("pin_frame_done_cnt", 32'(done_a), 32'd3);
    chk("pin_max_addr", 32'(max_addr), 32'd95);

    // mid-image asynchronous reset
    phase = 2;
    guard = 0;
    while (!(e_addr == IW * IH / 2 && e_rgb != 8'h00) && guard < 5000) begin
      tick();
      guard++;
    end
    chk("mid_image_timeout", 32'(e_addr == IW * IH / 2), 32'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_addr", vif.gpu_address, 32'd0);
    chk("async_rst_rgb", 32'(rgb_out), 32'h00);
    chk("async_rst_hsync", 32'(hsync), 32'd1);
    chk("async_rst_vsync", 32'(vsync), 32'd1);
    chk("async_rst_blank", 32'(blank_n), 32'd0);
    chk("async_rst_done", 32'(frame_done), 32'd0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    run_until_n(FT + 300, "post_reset_frame");
    repeat (3) @(negedge clk);
    chk("pin_done_after_abort", 32'(done_b), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
Display-side consumer of the CPU's VRAM read port. Generates 640x480@60 VGA timing and walks the VRAM read address across a centred IMG_W x IMG_H grayscale image, one pixel per pixel tick. Registers the returned 8-bit pixel into rgb_out with sync and blank aligned to it. Drives gpu_address into mide_cpu and consumes vram_out.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch
IMG_W, 300, image width (pixels)
IMG_H, 300, image height (lines)
IMG_X, 170, image left column in active area
IMG_Y, 90, image top line in active area
BORDER, 8'h00, pixel value outside the image window

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
pix_ce  in  1  pixel tick strobe, one clk wide; all state advances only when 1
vram_out  in  8  pixel data from VRAM; valid 1 clk after gpu_address changes
gpu_address  out  32  linear VRAM read address, bits [31:17] always 0
rgb_out  out  8  grayscale pixel to DAC
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
blank_n  out  1  1 inside the 640x480 active area
frame_done  out  1  one-clk pulse after the last image pixel of a frame is output

Behaviour:
- Reset (reset=0, async): h_cnt=0, v_cnt=0, gpu_address=0, rgb_out=0, hsync=1, vsync=1, blank_n=0, frame_done=0, internal pipeline flags cleared. Holds while reset=0. Frame restarts at (0,0) on release.
- H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL is computed the same way (525).
- Counters: on pix_ce, h_cnt increments and wraps H_TOTAL-1 -> 0. v_cnt increments on that wrap and wraps V_TOTAL-1 -> 0. With pix_ce=0, all registers hold.
- Stage 0 (counters -> address), updated on pix_ce for coordinate (h,v):
  - in_img = IMG_X <= h < IMG_X+IMG_W and IMG_Y <= v < IMG_Y+IMG_H.
  - Address is generated incrementally; no multiplier.
  - At (h,v)=(0,0), addr_next=0.
  - When in_img, gpu_address <= addr_next, then addr_next increments.
  - When not in_img, gpu_address holds its value.
  - Addresses run 0..IMG_W*IMG_H-1 (0..89999), row-major.
- Stage 1 (output): on the pix_ce following stage 0 for (h,v), the block registers the outputs for that coordinate.
  - blank_n = (h<H_ACTIVE && v<V_ACTIVE).
  - hsync = 0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync = 0 iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491).
  - rgb_out = vram_out if in_img, else BORDER if blank_n, else 0.
  - Fixed latency from coordinate to outputs: 1 pixel tick.
- vram_out is sampled at the stage-1 pix_ce. Requirement: at least 2 clk between pix_ce pulses (one-cycle synchronous VRAM). Behaviour with back-to-back pix_ce is undefined.
- frame_done is 1 for exactly one clk, the clk after stage 1 outputs the pixel at address IMG_W*IMG_H-1. It is 0 otherwise.
- Reset mid-frame: outputs return to reset values immediately. No partial frame_done. Next frame starts at address 0.
- Parameter legality (not checked in RTL): IMG_X+IMG_W <= H_ACTIVE, IMG_Y+IMG_H <= V_ACTIVE, IMG_W*IMG_H <= 2^17.

Test Plan:
- Reset: hold reset=0 with pix_ce toggling -> gpu_address=0, rgb_out=0, hsync=1, vsync=1, blank_n=0, frame_done=0 throughout. Release, pix_ce every 2 clk -> first line has hsync low for exactly 96 ticks starting at output h=656. Line period is 800 ticks.
- Frame timing: run 2 frames -> vsync low for 2 lines starting at line 490. Frame period is 420000 ticks. blank_n high for 640 ticks per line on lines 0..479 only.
- Image walk: VRAM model returns addr[7:0] -> first in-window output at (170,90) is 8'h00 and (171,90) is 8'h01. Last pixel (469,389) has address 89999 and rgb_out=8'h8F. Column 470 outputs BORDER.
- frame_done: count pulses over 3 frames -> exactly 3. Each pulse is 1 clk wide, the clk after pixel 89999 is output.
- Stall: hold pix_ce=0 for 50 clk mid-image -> gpu_address, rgb_out, syncs and counters unchanged. Resume continues with no skipped address.
- Reset mid-image at address 45000 -> async clear within the same clk. After release, next frame addresses restart at 0 and no frame_done occurs for the aborted frame.
